booth_seq_multiplier: RTL and testbench

Sequential radix-2 Booth multiplier for signed two's-complement operands. It consumes the add/subtract datapath of the ripple-carry adder-subtractor by instantiating it as its single arithmetic element, and performs one add, subtract or pass step per clock. Operands and product use valid/ready handshakes so the block can sit between an operand source and a result sink in the arithmetic pipeline.

---
 rtl/arith_pkg.sv | 31 +++
 rtl/ripple_carry_adder_subtractor.sv | 28 ++
 rtl/booth_seq_multiplier.sv | 130 +++++++++++++
 tb/tb_booth_seq_multiplier.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared encodings for the sequential arithmetic blocks: FSM states,
// Booth step codes and adder/subtractor control values.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_PASS = 2'd0,
        BOOTH_ADD  = 2'd1,
        BOOTH_SUB  = 2'd2
    } booth_op_t;

    localparam logic CTRL_ADD = 1'b0;
    localparam logic CTRL_SUB = 1'b1;

    // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], q_m1}.
    function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
        booth_op_t op;
        case ({q0, qm1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_PASS;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ripple_carry_adder_subtractor.sv
// Ripple-carry adder/subtractor: s = a + b when ctrl=0, s = a - b when ctrl=1
// (b inverted and ctrl injected as carry-in).
module ripple_carry_adder_subtractor #(
    parameter int SIZE = 16
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            ctrl,
    output logic [SIZE-1:0] s,
    output logic            c_out,
    output logic            ovf
);

    logic [SIZE:0] carry;

    assign carry[0] = ctrl;

    for (genvar i = 0; i < SIZE; i++) begin : g_bit
        logic b_x;
        assign b_x        = b[i] ^ ctrl;
        assign s[i]       = a[i] ^ b_x ^ carry[i];
        assign carry[i+1] = (a[i] & b_x) | (carry[i] & (a[i] ^ b_x));
    end

    assign c_out = carry[SIZE];
    assign ovf   = carry[SIZE] ^ carry[SIZE-1];

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier: one add/sub/pass step plus arithmetic
// shift per clock, valid/ready handshakes on operands and product.
module booth_seq_multiplier
    import arith_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   multiplicand,
    input  logic [SIZE-1:0]   multiplier,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] product,
    output logic              busy
);

    localparam int CW = $clog2(SIZE + 1);

    state_t              state_q, state_d;
    logic [SIZE:0]       m_q, m_d;
    logic [SIZE:0]       acc_q, acc_d;
    logic [SIZE-1:0]     q_q, q_d;
    logic                qm1_q, qm1_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*SIZE-1:0]   prod_q, prod_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;

    booth_op_t           op;
    logic                ctrl;
    logic [SIZE:0]       sum;
    logic [SIZE:0]       acc_step;
    logic                adder_cout_unused;
    logic                adder_ovf_unused;

    assign op   = booth_decode(q_q[0], qm1_q);
    assign ctrl = (op == BOOTH_SUB) ? CTRL_SUB : CTRL_ADD;

    // SIZE+1 bits wide so A - M cannot overflow even for M = -2^(SIZE-1).
    ripple_carry_adder_subtractor #(
        .SIZE(SIZE + 1)
    ) u_addsub (
        .a    (acc_q),
        .b    (m_q),
        .ctrl (ctrl),
        .s    (sum),
        .c_out(adder_cout_unused),
        .ovf  (adder_ovf_unused)
    );

    assign acc_step = (op == BOOTH_PASS) ? acc_q : sum;

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    m_d     = {multiplicand[SIZE-1], multiplicand};
                    acc_d   = '0;
                    q_d     = multiplier;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Arithmetic right shift of {A', Q, q_m1}.
                acc_d = {acc_step[SIZE], acc_step[SIZE:1]};
                q_d   = {acc_step[0], q_q[SIZE-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(SIZE - 1)) begin
                    state_d = ST_DONE;
                    prod_d  = {acc_d[SIZE-1:0], q_d};
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d == ST_RUN) || (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            m_q         <= '0;
            acc_q       <= '0;
            q_q         <= '0;
            qm1_q       <= 1'b0;
            cnt_q       <= '0;
            prod_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            m_q         <= m_d;
            acc_q       <= acc_d;
            q_q         <= q_d;
            qm1_q       <= qm1_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign product   = prod_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier (SIZE=16) with an expected-product queue.
module tb_booth_seq_multiplier;

    localparam int SIZE = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] multiplicand;
    logic [SIZE-1:0] multiplier;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     product;
    logic            busy;

    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          hs_cnt = 0;
    logic [31:0] sb[$];

    booth_seq_multiplier #(.SIZE(SIZE)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && out_valid && out_ready) hs_cnt++;
    end

    function automatic logic [31:0] ref_mul(input logic [15:0] m, input logic [15:0] q);
        logic signed [31:0] r;
        r = $signed(m) * $signed(q);
        return r;
    endfunction

    // Present one operand pair for one edge (block assumed IDLE) and queue its product.
    task automatic send(input logic [15:0] m, input logic [15:0] q);
        @(negedge clk);
        in_valid     = 1'b1;
        multiplicand = m;
        multiplier   = q;
        sb.push_back(ref_mul(m, q));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic take(output logic [31:0] got, output logic [31:0] exp);
        got = product;
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        multiplicand = '0; multiplier = '0;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_flags: in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
        end else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        total_cnt++;
        if (product !== 32'h0) $display("FAIL reset_product: got %h want 00000000", product);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL reset_idle: in_ready=%b want 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        int cyc;
        logic [31:0] got, exp;
        send(16'd3, 16'd5);
        total_cnt++;
        if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL basic_running: in_ready=%b busy=%b want 0 1", in_ready, busy);
        else pass_cnt++;
        wait_out(cyc);
        total_cnt++;
        if (cyc != 16) $display("FAIL basic_latency: got %0d cycles want 16", cyc);
        else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL basic_done_in_ready: got %b want 0", in_ready);
        else pass_cnt++;
        take(got, exp);
        total_cnt++;
        if (got !== 32'h0000000F) $display("FAIL basic_product: got %h want 0000000f", got);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL basic_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        else pass_cnt++;
    endtask

    task automatic test_corners();
        logic [15:0] tm[4];
        logic [15:0] tq[4];
        logic [31:0] tp[4];
        int cyc;
        logic [31:0] got, exp;
        tm = '{16'h8000, 16'h8000, 16'hFFFF, 16'h0000};
        tq = '{16'h8000, 16'h7FFF, 16'h0001, 16'h1234};
        tp = '{32'h40000000, 32'hC0008000, 32'hFFFFFFFF, 32'h00000000};
        for (int i = 0; i < 4; i++) begin
            send(tm[i], tq[i]);
            wait_out(cyc);
            total_cnt++;
            if (cyc != 16) $display("FAIL corner%0d_latency: got %0d cycles want 16", i, cyc);
            else pass_cnt++;
            take(got, exp);
            total_cnt++;
            if (got !== tp[i]) $display("FAIL corner%0d_product: got %h want %h", i, got, tp[i]);
            else pass_cnt++;
            total_cnt++;
            if (got !== exp) $display("FAIL corner%0d_model: got %h want %h", i, got, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [31:0] hold, got, exp;
        send(16'd100, 16'hFFFD);
        wait_out(cyc);
        hold = product;
        total_cnt++;
        if (hold !== 32'hFFFFFED4) $display("FAIL bp_product: got %h want fffffed4", hold);
        else pass_cnt++;
        exp = sb.pop_front();
        in_valid = 1'b1; multiplicand = 16'd7; multiplier = 16'd9;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== hold)
                $display("FAIL bp_stall%0d: out_valid=%b in_ready=%b product=%h want 1 0 %h", i, out_valid, in_ready, product, hold);
            else pass_cnt++;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total_cnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        else pass_cnt++;
        sb.push_back(ref_mul(16'd7, 16'd9));
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL bp_accept: busy=%b in_ready=%b want 1 0", busy, in_ready);
        else pass_cnt++;
        wait_out(cyc);
        total_cnt++;
        if (cyc != 16) $display("FAIL bp_latency: got %0d cycles want 16", cyc);
        else pass_cnt++;
        take(got, exp);
        total_cnt++;
        if (got !== 32'd63) $display("FAIL bp_new_product: got %h want 0000003f", got);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        logic seen;
        logic [31:0] got, exp, discard;
        send(16'h1234, 16'h5678);
        repeat (7) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL abort_busy: got %b want 1", busy);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        discard = sb.pop_front();
        total_cnt++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || product !== 32'h0)
            $display("FAIL abort_state: in_ready=%b busy=%b out_valid=%b product=%h want 1 0 0 00000000 (dropped %h)",
                     in_ready, busy, out_valid, product, discard);
        else pass_cnt++;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL abort_no_valid: out_valid seen=%b want 0", seen);
        else pass_cnt++;
        send(16'h7FFF, 16'h7FFF);
        wait_out(cyc);
        take(got, exp);
        total_cnt++;
        if (got !== 32'h3FFF0001) $display("FAIL abort_next_product: got %h want 3fff0001", got);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int cyc, hs0, n;
        logic [15:0] m, q;
        logic [31:0] got, exp;
        n = 1000;
        hs0 = hs_cnt;
        for (int i = 0; i < n; i++) begin
            m = 16'($urandom);
            q = 16'($urandom);
            send(m, q);
            wait_out(cyc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            take(got, exp);
            total_cnt++;
            if (got !== exp || out_valid !== 1'b0)
                $display("FAIL rand%0d: m=%h q=%h got %h out_valid=%b want %h 0", i, m, q, got, out_valid, exp);
            else pass_cnt++;
        end
        total_cnt++;
        if (hs_cnt - hs0 != n || sb.size() != 0)
            $display("FAIL rand_handshakes: got %0d handshakes queue=%0d want %0d 0", hs_cnt - hs0, sb.size(), n);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
